// File: rtl/spi_arb_pkg.sv
// spi_arb_pkg: shared arbiter state encoding, requester ids and divider counter width
package spi_arb_pkg;
  typedef enum logic [2:0] {IDLE, CS_SETUP, READY, SHIFT, CS_HOLD} state_t;
  localparam logic REQ_FLASH = 1'b0;
  localparam logic REQ_EEPROM = 1'b1;
  localparam int DIV_W = 8;
endpackage

// File: rtl/spi_byte_shifter.sv
// spi_byte_shifter: mode-0 MSB-first byte shifter clocked by a divided spi_c
module spi_byte_shifter
  import spi_arb_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk_dot4x,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx,
  input  logic       spi_q,
  output logic       done,
  output logic [7:0] rx,
  output logic       spi_c,
  output logic       spi_d
);
  logic act_q, act_d, sc_q, sc_d, samp_q, samp_d, tick, go;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d, rx_q, rx_d;
  always_comb begin
    tick = act_q && div_q == DIV_W'(CLK_DIV - 1);
    go = start && !act_q;
    done = tick && sc_q && bit_q == 3'd7;
    act_d = go ? 1'b1 : (done ? 1'b0 : act_q);
    div_d = (!act_q || tick) ? '0 : div_q + 1'b1;
    sc_d = tick ? !sc_q : sc_q;
    bit_d = go ? 3'd0 : ((tick && sc_q) ? bit_q + 3'd1 : bit_q);
    samp_d = (tick && !sc_q) ? spi_q : samp_q;
    sh_d = go ? tx : ((tick && sc_q) ? {sh_q[6:0], samp_q} : sh_q);
    rx_d = done ? {sh_q[6:0], samp_q} : rx_q;
  end
  always_ff @(posedge clk_dot4x) begin
    if (rst) begin
      act_q <= 1'b0;
      sc_q <= 1'b0;
      samp_q <= 1'b0;
      div_q <= '0;
      bit_q <= '0;
      sh_q <= '0;
      rx_q <= '0;
    end else begin
      act_q <= act_d;
      sc_q <= sc_d;
      samp_q <= samp_d;
      div_q <= div_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      rx_q <= rx_d;
    end
  end
  assign spi_c = sc_q;
  assign spi_d = act_q & sh_q[7];
  assign rx = rx_q;
endmodule

// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter: flash/EEPROM SPI bus arbiter and byte sequencer; SPI_ARB_ROUND_ROBIN_EN enables round-robin tie-break
module spi_bus_arbiter
  import spi_arb_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk_dot4x,
  input  logic       rst,
  input  logic       flash_req,
  output logic       flash_gnt,
  input  logic       flash_start,
  input  logic [7:0] flash_tx,
  input  logic       eeprom_req,
  output logic       eeprom_gnt,
  input  logic       eeprom_start,
  input  logic [7:0] eeprom_tx,
  output logic [7:0] rx_data,
  output logic       xfer_done,
  output logic       busy,
  output logic       spi_c,
  output logic       spi_d,
  input  logic       spi_q,
  output logic       flash_s,
  output logic       eeprom_s
);
  state_t state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic flash_gnt_q, flash_gnt_d, eeprom_gnt_q, eeprom_gnt_d, xfer_done_q, xfer_done_d;
  logic pick_e, req_g, start_g, cnt_end, sh_start, sh_done;
  logic [7:0] tx_g;
`ifdef SPI_ARB_ROUND_ROBIN_EN
  logic last_q, last_d;
  always_comb begin
    pick_e = eeprom_req && (!flash_req || last_q == REQ_FLASH);
    last_d = (state_q == IDLE && (flash_req || eeprom_req)) ? (pick_e ? REQ_EEPROM : REQ_FLASH) : last_q;
  end
  always_ff @(posedge clk_dot4x) last_q <= rst ? REQ_FLASH : last_d;
`else
  assign pick_e = eeprom_req;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    flash_gnt_d = flash_gnt_q;
    eeprom_gnt_d = eeprom_gnt_q;
    sh_start = 1'b0;
    req_g = flash_gnt_q ? flash_req : eeprom_req;
    start_g = flash_gnt_q ? flash_start : eeprom_start;
    tx_g = flash_gnt_q ? flash_tx : eeprom_tx;
    cnt_end = cnt_q == DIV_W'(CLK_DIV - 1);
    xfer_done_d = sh_done;
    case (state_q)
      IDLE: if (flash_req || eeprom_req) begin
        state_d = CS_SETUP;
        cnt_d = '0;
        eeprom_gnt_d = pick_e;
        flash_gnt_d = !pick_e;
      end
      CS_SETUP: begin
        cnt_d = cnt_end ? '0 : cnt_q + 1'b1;
        state_d = cnt_end ? READY : CS_SETUP;
      end
      READY: if (!req_g) begin
        state_d = CS_HOLD;
        cnt_d = '0;
        flash_gnt_d = 1'b0;
        eeprom_gnt_d = 1'b0;
      end else if (start_g) begin
        state_d = SHIFT;
        sh_start = 1'b1;
      end
      SHIFT: state_d = sh_done ? READY : SHIFT;
      CS_HOLD: begin
        cnt_d = cnt_end ? '0 : cnt_q + 1'b1;
        state_d = cnt_end ? IDLE : CS_HOLD;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_dot4x) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      flash_gnt_q <= 1'b0;
      eeprom_gnt_q <= 1'b0;
      xfer_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      flash_gnt_q <= flash_gnt_d;
      eeprom_gnt_q <= eeprom_gnt_d;
      xfer_done_q <= xfer_done_d;
    end
  end
  spi_byte_shifter #(.CLK_DIV(CLK_DIV)) u_shift (
    .clk_dot4x(clk_dot4x),
    .rst(rst),
    .start(sh_start),
    .tx(tx_g),
    .spi_q(spi_q),
    .done(sh_done),
    .rx(rx_data),
    .spi_c(spi_c),
    .spi_d(spi_d)
  );
  assign flash_gnt = flash_gnt_q;
  assign eeprom_gnt = eeprom_gnt_q;
  assign flash_s = !flash_gnt_q;
  assign eeprom_s = !eeprom_gnt_q;
  assign xfer_done = xfer_done_q;
  assign busy = state_q != IDLE;
endmodule
